read_write_fsm: RTL and testbench
=================================

READ_WRITE_FSM -- requirements
Module: read_write_fsm

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 Port clk: input, 1 bit; rising-edge clock for all state.
REQ-004 Port rst: input, 1 bit; synchronous active-low reset.
REQ-005 Port key_strobe: input, 1 bit; key-valid indication that qualifies isop and isdig.
REQ-006 Port isop: input, 1 bit; pressed key is an operator.
REQ-007 Port isdig: input, 1 bit; pressed key is a digit.
REQ-008 Port store_dig: output, 1 bit; high for one cycle to latch the current digit.
REQ-009 Port enter: output, 1 bit; high for one cycle when the first operand is committed.
REQ-010 Port result_ready: output, 1 bit; high for one cycle when the operator completes the second operand.

Function
REQ-011 The block SHALL be a Moore FSM with states IDLE1, DIG1, IDLE2, DIG2, IDLE3, ENTER, RESULT, plus a 1-bit operand flag (opnd: 0 = first, 1 = second).
REQ-012 A key event SHALL be an accepted key_strobe with exactly one of isdig/isop high; the enter key is an accepted strobe with isdig=0 and isop=0.
REQ-013 An event with isdig=1 and isop=1 SHALL be ignored, with no state change.
REQ-014 From IDLE1 or IDLE2, a digit event SHALL move to DIG1 or DIG2 respectively; other events are ignored.
REQ-015 DIG1 SHALL advance unconditionally to IDLE2 next cycle, and DIG2 to IDLE3.
REQ-016 In IDLE3 with opnd=0, the enter key SHALL move to ENTER; digit and operator events are ignored.
REQ-017 In IDLE3 with opnd=1, an operator event SHALL move to RESULT; digit and enter events are ignored.
REQ-018 ENTER SHALL set opnd=1 and return to IDLE1 next cycle.
REQ-019 RESULT SHALL clear opnd and return to IDLE1 next cycle.
REQ-020 Strobes arriving in DIG1, DIG2, ENTER or RESULT SHALL be dropped, not queued.
REQ-021 Outputs SHALL decode registered state only: store_dig=1 in DIG1/DIG2, enter=1 in ENTER, result_ready=1 in RESULT, all others 0.
REQ-022 At most one output SHALL be high in any cycle.
REQ-023 Latency SHALL be exactly one clock from the accepting edge to the output pulse.
REQ-024 Absent events, every IDLE state SHALL hold indefinitely.

Reset
REQ-025 When rst=0 at a rising clk edge, the FSM SHALL enter IDLE1 with opnd=0, and store_dig, enter and result_ready SHALL all be 0.
REQ-026 Reset SHALL override any event in the same cycle and abort any partial entry, including mid-operand.

Configuration
REQ-027 With READ_WRITE_FSM_STROBE_SYNC_EN defined, key_strobe SHALL pass through a 2-flop synchronizer plus rising-edge detect; one accepted event per low-to-high transition, adding 2 cycles latency. isop/isdig are sampled in the cycle the edge is detected.
REQ-028 Without READ_WRITE_FSM_STROBE_SYNC_EN, key_strobe SHALL be treated as an already synchronous single-cycle pulse and accepted in any cycle it is high.
REQ-029 The synchronizer flops SHALL reset to 0.

Verification (macro undefined)
REQ-030 Reset then idle 5 cycles, no strobe -> all outputs 0, state IDLE1.
REQ-031 Strobe digit, digit, enter (isop=0, isdig=0) -> store_dig pulses 1 cycle after each digit; enter=1 one cycle after enter key; opnd=1.
REQ-032 Continue: digit, digit, then strobe isop=1 -> two store_dig pulses; result_ready=1 for one cycle; back in IDLE1 with opnd=0.
REQ-033 In IDLE3 with opnd=0, strobe isop=1 -> no output, stays IDLE3; in IDLE2, strobe isop=0/isdig=0 -> stays IDLE2, outputs 0.
REQ-034 Strobe isdig=1 and isop=1 together in IDLE1 -> ignored; strobe held high in DIG1 -> dropped, FSM reaches IDLE2.
REQ-035 Assert rst=0 in IDLE3 with opnd=1 -> next cycle IDLE1, opnd=0, outputs 0; a following enter-key sequence needs two digits again.

Source files
------------

// File: rtl/read_write_fsm.sv
// Key-entry sequencer: two digits per operand, enter commits operand 1, operator completes operand 2.
// Define READ_WRITE_FSM_STROBE_SYNC_EN to synchronize and edge-detect an asynchronous key_strobe.
module read_write_fsm (
    input  logic clk,
    input  logic rst,
    input  logic key_strobe,
    input  logic isop,
    input  logic isdig,
    output logic store_dig,
    output logic enter,
    output logic result_ready
);

    typedef enum logic [2:0] {
        IDLE1  = 3'd0,
        DIG1   = 3'd1,
        IDLE2  = 3'd2,
        DIG2   = 3'd3,
        IDLE3  = 3'd4,
        ENTER  = 3'd5,
        RESULT = 3'd6
    } state_t;

    state_t state, state_nxt;
    logic   opnd, opnd_nxt;
    logic   strobe_ok;

`ifdef READ_WRITE_FSM_STROBE_SYNC_EN
    logic sync1, sync2, sync2_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= key_strobe;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    // One event per low-to-high transition of the synchronized strobe
    assign strobe_ok = sync2 & ~sync2_d;
`else
    assign strobe_ok = key_strobe;
`endif

    logic ev_dig, ev_op, ev_ent;
    assign ev_dig = strobe_ok &  isdig & ~isop;
    assign ev_op  = strobe_ok & ~isdig &  isop;
    assign ev_ent = strobe_ok & ~isdig & ~isop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE1;
            opnd  <= 1'b0;
        end else begin
            state <= state_nxt;
            opnd  <= opnd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        opnd_nxt  = opnd;
        unique case (state)
            IDLE1:  if (ev_dig) state_nxt = DIG1;
            DIG1:   state_nxt = IDLE2;
            IDLE2:  if (ev_dig) state_nxt = DIG2;
            DIG2:   state_nxt = IDLE3;
            IDLE3: begin
                if (!opnd && ev_ent)
                    state_nxt = ENTER;
                else if (opnd && ev_op)
                    state_nxt = RESULT;
            end
            ENTER: begin
                opnd_nxt  = 1'b1;
                state_nxt = IDLE1;
            end
            RESULT: begin
                opnd_nxt  = 1'b0;
                state_nxt = IDLE1;
            end
            default: state_nxt = IDLE1;
        endcase
    end

    always_comb begin
        store_dig    = (state == DIG1) || (state == DIG2);
        enter        = (state == ENTER);
        result_ready = (state == RESULT);
    end

endmodule

// File: tb/tb_read_write_fsm.sv
// Directed bench for read_write_fsm (default build); outputs checked as {store_dig, enter, result_ready}.
module tb_read_write_fsm;

    logic tb_clk = 1'b0;
    logic rst, key_strobe, isop, isdig;
    logic store_dig, enter, result_ready;
    int   checks   = 0;
    int   failures = 0;

    read_write_fsm dut (
        .clk          (tb_clk),
        .rst          (rst),
        .key_strobe   (key_strobe),
        .isop         (isop),
        .isdig        (isdig),
        .store_dig    (store_dig),
        .enter        (enter),
        .result_ready (result_ready)
    );

    always #5 tb_clk = ~tb_clk;

    localparam logic [2:0] NONE = 3'b000;
    localparam logic [2:0] DIG  = 3'b100;
    localparam logic [2:0] ENT  = 3'b010;
    localparam logic [2:0] RES  = 3'b001;

    task automatic check_out(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] outs();
        return {store_dig, enter, result_ready};
    endfunction

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    // Single-cycle key event; returns with outputs reflecting the accepting edge
    task automatic key(input logic d, input logic o);
        key_strobe = 1'b1;
        isdig      = d;
        isop       = o;
        step();
        key_strobe = 1'b0;
        isdig      = 1'b0;
        isop       = 1'b0;
    endtask

    // Two digits from IDLE1 leave the FSM in IDLE3
    task automatic two_digits(input string tag);
        key(1, 0); check_out({tag, "_d1"}, outs(), DIG);
        step();    check_out({tag, "_i2"}, outs(), NONE);
        key(1, 0); check_out({tag, "_d2"}, outs(), DIG);
        step();    check_out({tag, "_i3"}, outs(), NONE);
    endtask

    initial begin
        rst = 1'b0; key_strobe = 1'b0; isop = 1'b0; isdig = 1'b0;
        step(); step();
        check_out("reset", outs(), NONE);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_out("idle_hold", outs(), NONE);
        end

        // First operand then enter
        two_digits("op1");
        key(0, 0); check_out("enter_pulse", outs(), ENT);
        step();    check_out("enter_done", outs(), NONE);

        // Second operand then operator
        two_digits("op2");
        key(0, 1); check_out("result_pulse", outs(), RES);
        step();    check_out("result_done", outs(), NONE);

        // opnd cleared: enter key in IDLE3 is accepted again, operator ignored
        two_digits("op3");
        key(0, 1); check_out("idle3_op_ignored", outs(), NONE);
        key(1, 0); check_out("idle3_dig_ignored", outs(), NONE);
        key(0, 0); check_out("idle3_enter", outs(), ENT);
        step();

        // opnd=1: enter key in IDLE2 ignored; IDLE2 holds
        key(1, 0); check_out("b_d1", outs(), DIG);
        step();
        key(0, 0); check_out("idle2_enter_ignored", outs(), NONE);
        key(0, 1); check_out("idle2_op_ignored", outs(), NONE);
        for (int i = 0; i < 4; i++) step();
        check_out("idle2_hold", outs(), NONE);
        key(1, 0); check_out("idle2_dig", outs(), DIG);
        step();
        key(1, 0); check_out("idle3_op1_dig_ignored", outs(), NONE);
        key(0, 0); check_out("idle3_op1_ent_ignored", outs(), NONE);
        key(0, 1); check_out("idle3_op1_result", outs(), RES);
        step();

        // Both flags set: ignored; enter/operator in IDLE1 ignored
        key(1, 1); check_out("both_ignored", outs(), NONE);
        key(0, 0); check_out("idle1_enter_ignored", outs(), NONE);
        key(0, 1); check_out("idle1_op_ignored", outs(), NONE);

        // Strobe held through DIG1 is dropped, FSM sits in IDLE2
        key_strobe = 1'b1; isdig = 1'b1;
        step(); check_out("held_dig1", outs(), DIG);
        step(); check_out("held_dropped", outs(), NONE);
        key_strobe = 1'b0; isdig = 1'b0;
        step(); check_out("held_idle2", outs(), NONE);
        key(1, 0); check_out("held_dig2", outs(), DIG);
        step();
        key(0, 0); check_out("held_enter", outs(), ENT);
        step();

        // Reset in IDLE3 with opnd=1 overrides a simultaneous operator event
        two_digits("rs");
        rst = 1'b0;
        key(0, 1); check_out("rst_override", outs(), NONE);
        rst = 1'b1;
        key(0, 0); check_out("rst_idle1_enter", outs(), NONE);
        key(1, 0); check_out("rst_d1", outs(), DIG);
        step();
        key(0, 0); check_out("rst_partial_enter", outs(), NONE);
        key(1, 0); check_out("rst_d2", outs(), DIG);
        step();
        key(0, 1); check_out("rst_opnd_cleared", outs(), NONE);
        key(0, 0); check_out("rst_enter", outs(), ENT);
        step();    check_out("final_idle", outs(), NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
